// File: rtl/clk_div_gen.sv
// Synchronous clock-divider generator: N_OUT phase-aligned divided clocks
// produced as flops in the clk domain, with rise/fall strobes and a locked flag.
module clk_div_gen #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned BASE_DIV = 5,
    parameter int unsigned N_OUT    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             div_ld,
    input  logic [CNT_W-1:0] div_in,
    output logic [N_OUT-1:0] clk_out,
    output logic [N_OUT-1:0] stb_rise,
    output logic [N_OUT-1:0] stb_fall,
    output logic             locked,
    output logic [CNT_W-1:0] half_cur
);

    localparam logic [CNT_W-1:0] BASE_HALF = CNT_W'(BASE_DIV);

    logic [CNT_W-1:0] pre_cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_m1;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] pend_in;
    logic             pend_vld;
    logic [N_OUT-1:0] phase;
    logic [N_OUT-1:0] next_phase;
    logic             tick;
    logic             wrap;

    // half is never 0, so half-1 cannot underflow; >= lets a lowered half end early
    always_comb begin
        half_m1    = half - CNT_W'(1);
        tick       = enb && (pre_cnt >= half_m1);
        next_phase = phase + N_OUT'(1);
        wrap       = tick && (next_phase == '0);
        pend_in    = (div_in == '0) ? CNT_W'(1) : div_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt  <= '0;
            phase    <= '0;
            half     <= BASE_HALF;
            pend     <= BASE_HALF;
            pend_vld <= 1'b0;
            clk_out  <= '0;
            stb_rise <= '0;
            stb_fall <= '0;
            locked   <= 1'b0;
        end else begin
            stb_rise <= '0;
            stb_fall <= '0;

            if (!enb) begin
                pre_cnt <= '0;
            end else if (tick) begin
                pre_cnt  <= '0;
                phase    <= next_phase;
                clk_out  <= next_phase;
                stb_rise <= ~phase & next_phase;
                stb_fall <= phase & ~next_phase;
            end else begin
                pre_cnt <= pre_cnt + CNT_W'(1);
            end

            // Ratio is swapped only at the all-outputs-low wrap; a coincident
            // div_ld lands in pend after the old pending value is consumed.
            if (wrap && pend_vld) begin
                half <= pend;
            end
            if (div_ld) begin
                pend     <= pend_in;
                pend_vld <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end

            if (div_ld || !enb) begin
                locked <= 1'b0;
            end else if (wrap && !pend_vld) begin
                locked <= 1'b1;
            end
        end
    end

    assign half_cur = half;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of the divider.
module tb_clk_div_gen;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned BASE_DIV = 5;
    localparam int unsigned N_OUT    = 3;
    localparam int          PMASK    = (1 << N_OUT) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enb = 1'b0;
    logic             div_ld = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic [N_OUT-1:0] clk_out;
    logic [N_OUT-1:0] stb_rise;
    logic [N_OUT-1:0] stb_fall;
    logic             locked;
    logic [CNT_W-1:0] half_cur;

    int checks = 0;
    int errors = 0;

    // Model state: enabled cycles spent in the current half-period, output
    // phase as an integer, active/pending half-period, derived flags.
    int m_run, m_phase, m_half, m_pend, m_rise, m_fall;
    bit m_pend_vld, m_locked;

    clk_div_gen #(
        .CNT_W    (CNT_W),
        .BASE_DIV (BASE_DIV),
        .N_OUT    (N_OUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .div_ld   (div_ld),
        .div_in   (div_in),
        .clk_out  (clk_out),
        .stb_rise (stb_rise),
        .stb_fall (stb_fall),
        .locked   (locked),
        .half_cur (half_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit ld, input int din);
        int  np;
        bit  was_pend;
        m_rise = 0;
        m_fall = 0;
        if (r) begin
            m_run = 0; m_phase = 0; m_half = BASE_DIV; m_pend_vld = 0; m_locked = 0;
        end else begin
            if (!e) begin
                m_run    = 0;
                m_locked = 0;
            end else begin
                m_run++;
                if (m_run >= m_half) begin
                    np      = (m_phase + 1) % (1 << N_OUT);
                    m_rise  = ~m_phase & np & PMASK;
                    m_fall  = m_phase & ~np & PMASK;
                    m_phase = np;
                    m_run   = 0;
                    if (np == 0) begin
                        was_pend = m_pend_vld;
                        if (m_pend_vld) begin
                            m_half     = m_pend;
                            m_pend_vld = 0;
                        end
                        if (!was_pend && !ld) m_locked = 1;
                    end
                end
            end
            if (ld) begin
                m_pend     = (din == 0) ? 1 : din;
                m_pend_vld = 1;
                m_locked   = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit ld, input int din);
        rst    = r;
        enb    = e;
        div_ld = ld;
        div_in = din[CNT_W-1:0];
        @(posedge clk);
        model(r, e, ld, din);
        #1;
        chk("clk_out",  32'(clk_out),  32'(m_phase));
        chk("stb_rise", 32'(stb_rise), 32'(m_rise));
        chk("stb_fall", 32'(stb_fall), 32'(m_fall));
        chk("locked",   32'(locked),   32'(m_locked));
        chk("half_cur", 32'(half_cur), 32'(m_half));
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    // Run enabled until the model sits at the given phase, 2 cycles into the half.
    task automatic run_to_phase(input int target);
        bit found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(0, 1, 0, 0);
            if (m_phase == target && m_run == 2) found = 1;
        end
        chk("run_to_phase_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        // Reset values and base-ratio startup.
        do_reset();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_half", 32'(half_cur), 32'(BASE_DIV));
        for (int k = 1; k <= 40; k++) begin
            step(0, 1, 0, 0);
            if (k == 4)  chk("pre_rise_clk", 32'(clk_out), 32'd0);
            if (k == 5)  chk("first_rise_clk", 32'(clk_out), 32'd1);
            if (k == 5)  chk("first_rise_stb", 32'(stb_rise), 32'd1);
            if (k == 39) chk("unlocked_39", 32'(locked), 32'd0);
            if (k == 40) chk("locked_40", 32'(locked), 32'd1);
        end

        // Ratio change to 3 requested at cycle 12.
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            step(0, 1, k == 12, 3);
            if (k == 13) chk("ld_locked_13", 32'(locked), 32'd0);
            if (k == 39) chk("half_before_wrap", 32'(half_cur), 32'd5);
            if (k == 40) chk("half_at_wrap", 32'(half_cur), 32'd3);
            if (k == 63) chk("relock_63", 32'(locked), 32'd0);
            if (k == 64) chk("relock_64", 32'(locked), 32'd1);
        end

        // div_in = 0 and div_in = 1 both give the minimum half-period.
        step(0, 1, 1, 0);
        for (int k = 0; k < 60; k++) step(0, 1, 0, 0);
        chk("half_from_0", 32'(half_cur), 32'd1);
        step(0, 1, 1, 5);
        for (int k = 0; k < 60; k++) step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        for (int k = 0; k < 60; k++) step(0, 1, 0, 0);
        chk("half_from_1", 32'(half_cur), 32'd1);
        for (int k = 0; k < 16; k++) step(0, 1, 0, 0);

        // enb dropped mid-period with clk_out = 3'b011, then restarted.
        do_reset();
        run_to_phase(3);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0);
            chk("hold_clk", 32'(clk_out), 32'd3);
        end
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 0, 0);
            if (k == 4) chk("reen_before_tick", 32'(clk_out), 32'd3);
            if (k == 5) chk("reen_tick", 32'(clk_out), 32'd4);
        end

        // rst mid-period with clk_out = 3'b101 and a pending ratio.
        do_reset();
        run_to_phase(5);
        step(0, 1, 1, 9);
        step(1, 1, 1, 2);
        chk("rst_mid_clk", 32'(clk_out), 32'd0);
        chk("rst_mid_half", 32'(half_cur), 32'(BASE_DIV));
        for (int k = 0; k < 45; k++) step(0, 1, 0, 0);
        chk("pend_discarded", 32'(half_cur), 32'(BASE_DIV));

        // Back-to-back loads: last one wins, the first never shows.
        do_reset();
        step(0, 1, 1, 4);
        step(0, 1, 1, 7);
        for (int k = 0; k < 45; k++) begin
            step(0, 1, 0, 0);
            chk("no_half_4", 32'(half_cur == 8'd4), 32'd0);
        end
        chk("half_last_wins", 32'(half_cur), 32'd7);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bit r, e, ld;
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 19) != 0);
            ld = ($urandom_range(0, 59) == 0);
            step(r, e, ld, int'($urandom_range(0, 9)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised synchronous clock-divider generator. Derives N_OUT divided clocks from the fastest device clock.
- Every output is a flop in the clk domain: no ripple clocking, all outputs phase-aligned.
- Provides per-output rise/fall strobes for logic that must stay on clk, a run-time programmable base divide, and a locked flag.
- Sits at top level, feeding the 10/20/40-class clocks to the serialiser, deserialiser and PCS blocks.

Parameters:
- CNT_W, 8, width of the prescaler counter and of the divide value.
- BASE_DIV, 5, reset value of the half-period of clk_out[0], in clk cycles. Must be 1..2^CNT_W-1.
- N_OUT, 3, number of divided outputs. clk_out[i] half-period = half*2^i clk cycles.

Ports:
- clk  in  1  fast source clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  run enable.
- div_ld  in  1  one-cycle request to load div_in as a new half-period.
- div_in  in  CNT_W  requested half-period; 0 is treated as 1.
- clk_out  out  N_OUT  divided clocks; bit 0 is fastest.
- stb_rise  out  N_OUT  1-cycle pulse coincident with the 0->1 transition of clk_out[i].
- stb_fall  out  N_OUT  1-cycle pulse coincident with the 1->0 transition of clk_out[i].
- locked  out  1  outputs are running with a stable, applied ratio.
- half_cur  out  CNT_W  half-period currently in effect.

Behaviour:
- Reset (rst=1 at posedge):
  - pre_cnt=0, phase=0, half=BASE_DIV, pend_vld=0.
  - clk_out=0, stb_rise=0, stb_fall=0, locked=0, half_cur=BASE_DIV.
  - rst has priority over enb and div_ld, including mid-period; outputs drop to 0 on the next edge with no partial pulse.
- Prescaler:
  - While enb=1, pre_cnt increments each clk.
  - When pre_cnt >= half-1 it is the tick cycle: pre_cnt <= 0.
  - Comparison is >=, so a half lowered below the current pre_cnt still terminates on the next cycle.
- Phase counter:
  - N_OUT-bit register phase; increments modulo 2^N_OUT on each tick.
  - clk_out = phase, registered, so each bit is glitch-free and all rising edges are aligned when phase wraps to 0.
  - Example at BASE_DIV=5: clk_out[0] has a 10-cycle period, clk_out[1] 20, clk_out[2] 40. All outputs are 50% duty.
- Strobes:
  - On a tick, stb_rise[i] <= ~phase[i] & next_phase[i], and stb_fall[i] <= phase[i] & ~next_phase[i].
  - Otherwise stb_rise and stb_fall are 0.
  - Each strobe is high in exactly the cycle in which the clk_out bit shows its new value.
- Ratio change:
  - div_ld=1 captures max(div_in,1) into pend and sets pend_vld. A later div_ld before application overwrites pend (last wins).
  - Application happens on the tick where next_phase==0 (all outputs falling or low): half <= pend, half_cur <= pend, pend_vld <= 0.
  - Applying at that point guarantees no truncated high phase on any output.
  - If div_ld coincides with the applying tick, the new value is captured as pending and the old pending value is applied.
- enb=0:
  - pre_cnt held at 0; phase and clk_out hold their level; strobes 0; locked <= 0.
  - Pending ratio is retained.
  - On enb re-assertion, counting restarts from pre_cnt=0.
- locked:
  - Set on a tick where next_phase==0 with enb=1 and no ratio pending after that tick.
  - Cleared by rst, by enb=0, and in the cycle following any div_ld.
  - Re-asserts at the first wrap after the new ratio is applied.
- Widths:
  - pre_cnt and half are CNT_W bits; pre_cnt never exceeds half-1, so there is no overflow.
  - The phase wrap from 2^N_OUT-1 to 0 is the natural modulo.

Test Plan:
- Reset then enb=1, BASE_DIV=5, N_OUT=3:
  - First clk_out[0] rise and stb_rise[0] on the 5th posedge after rst drops; clk_out[0] period 10, [1] 20, [2] 40 cycles.
  - locked=1 at the 40th posedge.
- Ratio change: div_ld with div_in=3 at cycle 12:
  - locked drops at cycle 13; half_cur stays 5 until the phase wrap at cycle 40.
  - From then clk_out[0] period is 6 cycles; locked re-asserts at the next wrap, 24 cycles later.
- div_in=0 and div_in=1 each loaded:
  - Both give half=1, clk_out[0] toggling every cycle, clk_out[2] period 8.
  - Strobes are continuous but each stays 1 cycle wide.
- enb dropped mid-period while clk_out=3'b011:
  - Outputs hold 3'b011, strobes 0, locked=0.
  - After re-enable, the next tick comes exactly half cycles later.
- rst asserted mid-period with clk_out=3'b101 and a pending div_ld:
  - Next edge gives clk_out=0, half_cur=BASE_DIV, and the pending value is discarded.
- Back-to-back div_ld of 4 then 7 before a wrap:
  - Only 7 is applied at the wrap; the 4 value never appears on half_cur.
